// File: rtl/nios_cpu_cpu_debug_mem_arbiter.sv
// Debug-memory arbiter: shares one single-port debug RAM between the JTAG host
// command path (MonAReg/MonDReg) and an Avalon slave port.
`timescale 1ns/1ps
module nios_cpu_cpu_debug_mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic [37:0] jdo,
  input  logic [7:0]  av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  input  logic [3:0]  av_byteenable,
  input  logic        av_debugaccess,
  output logic [31:0] av_readdata,
  output logic        av_waitrequest,
  output logic [7:0]  ram_addr,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_be,
  input  logic [31:0] ram_rdata,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {IDLE, HOST_RD, AV_RD, AV_ACK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mon_a_q, mon_a_d;
  logic [31:0] mon_d_q, mon_d_d;
  logic [31:0] av_rdata_q, av_rdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic        pend_q, pend_d;
  logic        pend_wr_q, pend_wr_d;
  logic        err_q, err_d;
  logic        last_host_q, last_host_d;

  logic av_req;
  logic host_busy;
  logic unused_jdo;

  assign av_req     = av_read | av_write;
  assign host_busy  = pend_q | (state_q == HOST_RD);
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  always_comb begin
    state_d     = state_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    av_rdata_d  = av_rdata_q;
    wdata_d     = wdata_q;
    pend_d      = pend_q;
    pend_wr_d   = pend_wr_q;
    err_d       = err_q;
    last_host_d = last_host_q;
    ram_addr    = 8'h00;
    ram_rd      = 1'b0;
    ram_wr      = 1'b0;
    ram_wdata   = 32'h0;
    ram_be      = 4'h0;

    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time is granted.
        if (pend_q && (!av_req || !last_host_q)) begin
          last_host_d = 1'b1;
          ram_addr    = mon_a_q;
          if (pend_wr_q) begin
            ram_wr    = 1'b1;
            ram_be    = 4'hF;
            ram_wdata = wdata_q;
            mon_a_d   = mon_a_q + 8'd1;
            pend_d    = 1'b0;
          end else begin
            ram_rd  = 1'b1;
            state_d = HOST_RD;
          end
        end else if (av_req) begin
          last_host_d = 1'b0;
          ram_addr    = av_address;
          if (av_read) begin
            ram_rd  = 1'b1;
            state_d = AV_RD;
          end else begin
            if (av_debugaccess) begin
              ram_wr    = 1'b1;
              ram_be    = av_byteenable;
              ram_wdata = av_writedata;
            end
            state_d = AV_ACK;
          end
        end
      end
      HOST_RD: begin
        mon_d_d = ram_rdata;
        mon_a_d = mon_a_q + 8'd1;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      AV_RD: begin
        av_rdata_d = ram_rdata;
        state_d    = AV_ACK;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are evaluated last so an address load overrides a completing increment.
    if (take_action_ocimem_a) begin
      mon_a_d   = jdo[33:26];
      err_d     = take_action_ocimem_b | take_no_action_ocimem_a;
      pend_d    = jdo[34];
      pend_wr_d = 1'b0;
    end else if (take_action_ocimem_b) begin
      if (host_busy || take_no_action_ocimem_a) begin
        err_d = 1'b1;
      end
      if (!host_busy) begin
        pend_d    = 1'b1;
        pend_wr_d = 1'b1;
        wdata_d   = jdo[34:3];
      end
    end else if (take_no_action_ocimem_a) begin
      if (host_busy) begin
        err_d = 1'b1;
      end else begin
        pend_d    = 1'b1;
        pend_wr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mon_a_q     <= 8'h00;
      mon_d_q     <= 32'h0;
      av_rdata_q  <= 32'h0;
      wdata_q     <= 32'h0;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      err_q       <= 1'b0;
      last_host_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      av_rdata_q  <= av_rdata_d;
      wdata_q     <= wdata_d;
      pend_q      <= pend_d;
      pend_wr_q   <= pend_wr_d;
      err_q       <= err_d;
      last_host_q <= last_host_d;
    end
  end

  assign av_waitrequest = av_req & (state_q != AV_ACK);
  assign av_readdata    = av_rdata_q;
  assign MonDReg        = mon_d_q;
  assign monitor_ready  = ~pend_q;
  assign monitor_error  = err_q;

endmodule

// File: tb/tb_nios_cpu_cpu_debug_mem_arbiter.sv
// Directed bench for the debug-memory arbiter with a behavioural registered-read RAM.
`timescale 1ns/1ps
module tb_nios_cpu_cpu_debug_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [37:0] jdo = '0;
  logic [7:0]  av_address = '0;
  logic        av_read = 1'b0;
  logic        av_write = 1'b0;
  logic [31:0] av_writedata = '0;
  logic [3:0]  av_byteenable = '0;
  logic        av_debugaccess = 1'b0;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_checks = 0;
  int n_errors = 0;
  int rd_count = 0;
  int wr_count = 0;
  bit mem_init = 1'b0;
  logic [31:0] mem [0:255];

  nios_cpu_cpu_debug_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .jdo(jdo), .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_debugaccess(av_debugaccess), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  // RAM model: preset pattern {4{addr}} except 0x10, byte-enabled writes, registered read.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= {4{i[7:0]}};
      mem[8'h10] <= 32'hCAFEF00D;
      mem_init   <= 1'b1;
    end else begin
      if (ram_rd && ram_wr) begin
        $display("FAIL rd_wr_both: ram_rd=1 ram_wr=1 required not both");
        n_errors++;
      end
      if (ram_rd) begin
        ram_rdata <= mem[ram_addr];
        rd_count++;
      end
      if (ram_wr) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        wr_count++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    return {3'b000, rd, addr, 26'h0};
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    return {3'b000, data, 3'b000};
  endfunction

  // Pulse the given strobes for one cycle; returns at the following negedge + 1.
  task automatic strobe(input logic sa, input logic sb, input logic sn, input logic [37:0] j);
    @(negedge clk);
    take_action_ocimem_a = sa; take_action_ocimem_b = sb; take_no_action_ocimem_a = sn; jdo = j;
    @(negedge clk);
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    #1;
  endtask

  task automatic host_read(input string tag, input logic [7:0] exp_addr, input logic [31:0] exp_data);
    int n = 0;
    while (!ram_rd && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_rd_seen"}, {31'b0, ram_rd}, 32'd1);
    check({tag, "_rd_addr"}, {24'b0, ram_addr}, {24'b0, exp_addr});
    @(negedge clk); #1;
    check({tag, "_busy"}, {31'b0, monitor_ready}, 32'd0);
    @(negedge clk); #1;
    check({tag, "_data"}, MonDReg, exp_data);
    check({tag, "_ready"}, {31'b0, monitor_ready}, 32'd1);
  endtask

  task automatic host_write(input string tag, input logic [7:0] exp_addr, input logic [31:0] exp_data);
    int n = 0;
    while (!ram_wr && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_wr_seen"}, {31'b0, ram_wr}, 32'd1);
    check({tag, "_wr_addr"}, {24'b0, ram_addr}, {24'b0, exp_addr});
    check({tag, "_wr_be"}, {28'b0, ram_be}, 32'hF);
    @(negedge clk); #1;
    check({tag, "_mem"}, mem[exp_addr], exp_data);
    check({tag, "_ready"}, {31'b0, monitor_ready}, 32'd1);
  endtask

  task automatic av_ack_wait(input string tag);
    int n = 0;
    while (av_waitrequest && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_ack"}, {31'b0, av_waitrequest}, 32'd0);
  endtask

  initial begin
    int rc;
    int wc;
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int wc;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'b0, monitor_ready}, 32'd1);
    check("rst_error", {31'b0, monitor_error}, 32'd0);
    check("rst_mond", MonDReg, 32'h0);
    check("rst_rdwr", {30'b0, ram_rd, ram_wr}, 32'd0);
    check("rst_avrd", av_readdata, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // Address load with read: RAM[0x10] into MonDReg, pointer advances to 0x11.
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1));
    host_read("ld_rd", 8'h10, 32'hCAFEF00D);
    strobe(1'b0, 1'b0, 1'b1, '0);
    host_read("inc_rd", 8'h11, 32'h11111111);

    // Write at 0xFF wraps the pointer to 0x00.
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0));
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678));
    host_write("wr_ff", 8'hFF, 32'h12345678);
    strobe(1'b0, 1'b0, 1'b1, '0);
    host_read("wrap_rd", 8'h00, 32'h00000000);

    // Second read strobe while the first is in flight is dropped.
    rc = rd_count;
    strobe(1'b0, 1'b0, 1'b1, '0);
    strobe(1'b0, 1'b0, 1'b1, '0);
    check("drop_error", {31'b0, monitor_error}, 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check("drop_rdcount", rd_count - rc, 32'd1);
    check("drop_data", MonDReg, 32'h01010101);
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h30, 1'b0));
    check("clr_error", {31'b0, monitor_error}, 32'd0);

    // ocimem_a and ocimem_b together: the write loses and is flagged.
    wc = wr_count;
    strobe(1'b1, 1'b1, 1'b0, jdo_a(8'h60, 1'b0));
    check("coll_error", {31'b0, monitor_error}, 32'd1);
    check("coll_ready", {31'b0, monitor_ready}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("coll_nowrite", wr_count - wc, 32'd0);

    // Reset, then a host and an Avalon read contend: host wins the first tie.
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    rc = rd_count;
    @(negedge clk); take_no_action_ocimem_a = 1'b1;
    @(negedge clk); take_no_action_ocimem_a = 1'b0; av_read = 1'b1; av_address = 8'h40;
    #1;
    check("tie_host_rd", {31'b0, ram_rd}, 32'd1);
    check("tie_host_addr", {24'b0, ram_addr}, 32'h00);
    check("tie_wait", {31'b0, av_waitrequest}, 32'd1);
    av_ack_wait("tie_av");
    check("tie_avdata", av_readdata, 32'h40404040);
    check("tie_rdcount", rd_count - rc, 32'd2);
    @(negedge clk); #1;
    check("tie_wait_again", {31'b0, av_waitrequest}, 32'd1);
    av_read = 1'b0;

    // Non-debug Avalon write is acknowledged but never reaches the RAM.
    wc = wr_count;
    @(negedge clk);
    av_write = 1'b1; av_address = 8'h50; av_writedata = 32'hDEADBEEF;
    av_byteenable = 4'hF; av_debugaccess = 1'b0;
    #1;
    check("avw_nd_ramwr", {31'b0, ram_wr}, 32'd0);
    av_ack_wait("avw_nd");
    @(negedge clk); av_write = 1'b0; #1;
    check("avw_nd_mem", mem[8'h50], 32'h50505050);
    check("avw_nd_count", wr_count - wc, 32'd0);

    // Debug Avalon write with partial byte enables.
    @(negedge clk);
    av_write = 1'b1; av_writedata = 32'hAABBCCDD; av_byteenable = 4'b0011; av_debugaccess = 1'b1;
    #1;
    check("avw_d_ramwr", {31'b0, ram_wr}, 32'd1);
    check("avw_d_be", {28'b0, ram_be}, 32'h3);
    av_ack_wait("avw_d");
    @(negedge clk); av_write = 1'b0; #1;
    check("avw_d_mem", mem[8'h50], 32'h5050CCDD);

    // Reset during HOST_RD abandons the read with no pointer increment.
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h11, 1'b1));
    host_read("pre_rst", 8'h11, 32'h11111111);
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h60, 1'b1));
    check("mid_rd_addr", {24'b0, ram_addr}, 32'h60);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_mond", MonDReg, 32'h0);
    check("mid_rst_ready", {31'b0, monitor_ready}, 32'd1);
    check("mid_rst_rd", {31'b0, ram_rd}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    strobe(1'b0, 1'b0, 1'b1, '0);
    host_read("post_rst", 8'h00, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
